game_command_scheduler: RTL and testbench

- Sits between the raw player buttons and the GameEngine move datapath.
- Converts the four buttons plus an internal gravity timer into a single serialized stream of move commands.
- Handshakes each command to the engine with valid/ready; the engine applies exactly one piece action per accepted command.
- Owns press detection, auto-repeat for held left/right, command priority, and halting on game over.

---
 rtl/game_command_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_game_command_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_command_scheduler.sv
// Turns raw player buttons plus a gravity timer into one serialized stream of
// move commands, handed to the engine over a valid/ready handshake.
module game_command_scheduler #(
   parameter int unsigned GRAVITY_PERIOD = 25000000,
   parameter int unsigned DAS_DELAY      = 8000000,
   parameter int unsigned DAS_REPEAT     = 2000000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       right_move_button,
   input  logic       left_move_button,
   input  logic       direct_down_button,
   input  logic       hold_button,
   input  logic       game_over,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd_code
);

   localparam int unsigned NBTN = 4;
   localparam int unsigned NCMD = 5;

   // bit positions shared by button and pending vectors
   localparam int unsigned C_LEFT  = 0;
   localparam int unsigned C_RIGHT = 1;
   localparam int unsigned C_DROP  = 2;
   localparam int unsigned C_HOLD  = 3;
   localparam int unsigned C_GRAV  = 4;

   localparam logic [2:0] CODE_NONE  = 3'd0;
   localparam logic [2:0] CODE_LEFT  = 3'd1;
   localparam logic [2:0] CODE_RIGHT = 3'd2;
   localparam logic [2:0] CODE_DROP  = 3'd3;
   localparam logic [2:0] CODE_HOLD  = 3'd4;
   localparam logic [2:0] CODE_GRAV  = 3'd5;

   localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_PERIOD - 1);
   localparam logic [CNT_W-1:0] DAS_FIRST = CNT_W'(DAS_DELAY - 1);
   localparam logic [CNT_W-1:0] DAS_NEXT  = CNT_W'(DAS_REPEAT - 1);

   typedef enum logic [1:0] {IDLE, OFFER, HALTED} state_e;

   state_e          state_q, state_d;
   logic            valid_d;
   logic [2:0]      code_d;
   logic            take;
   logic            halt;
   logic            piece_done;
   logic [NBTN-1:0] raw, sync1, sync2, sync2_prev, press;
   logic [1:0]      das_evt;
   logic [CNT_W-1:0] grav_cnt;
   logic            grav_evt;
   logic [NCMD-1:0] pend_q, pend_d, pend_eff, ev, sel_oh;
   logic [2:0]      sel_code;

   assign raw   = {hold_button, direct_down_button, right_move_button, left_move_button};
   assign press = sync2 & ~sync2_prev;
   assign halt  = game_over | (state_q == HALTED);

   // a placed piece (DROP/HOLD accepted) restarts gravity for the next piece
   assign piece_done = cmd_valid & cmd_ready &
                       ((cmd_code == CODE_DROP) | (cmd_code == CODE_HOLD));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1      <= '0;
         sync2      <= '0;
         sync2_prev <= '0;
      end else begin
         sync1      <= raw;
         sync2      <= sync1;
         sync2_prev <= sync2;
      end
   end

   // Auto-repeat: the press cycle itself is the first event, counting starts after it.
   for (genvar i = 0; i < 2; i++) begin : g_das
      logic [CNT_W-1:0] cnt;
      logic             rep;

      assign das_evt[i] = sync2[i] & ~press[i] & (cnt == (rep ? DAS_NEXT : DAS_FIRST));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
            rep <= 1'b0;
         end else if (halt || !sync2[i] || press[i]) begin
            cnt <= '0;
            rep <= 1'b0;
         end else if (das_evt[i]) begin
            cnt <= '0;
            rep <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign grav_evt = (grav_cnt == GRAV_LAST) & ~halt & ~piece_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grav_cnt <= '0;
      end else if (halt || piece_done || grav_cnt == GRAV_LAST) begin
         grav_cnt <= '0;
      end else begin
         grav_cnt <= grav_cnt + CNT_W'(1);
      end
   end

   assign ev = {grav_evt, press[C_HOLD], press[C_DROP],
                press[C_RIGHT] | das_evt[C_RIGHT], press[C_LEFT] | das_evt[C_LEFT]};

   // gravity queued before a piece lands must not be issued for the new piece
   assign pend_eff = pend_q & ~(NCMD'(piece_done) << C_GRAV);

   always_comb begin
      sel_oh   = '0;
      sel_code = CODE_NONE;
      if (pend_eff[C_HOLD]) begin
         sel_oh[C_HOLD] = 1'b1;
         sel_code       = CODE_HOLD;
      end else if (pend_eff[C_DROP]) begin
         sel_oh[C_DROP] = 1'b1;
         sel_code       = CODE_DROP;
      end else if (pend_eff[C_LEFT]) begin
         sel_oh[C_LEFT] = 1'b1;
         sel_code       = CODE_LEFT;
      end else if (pend_eff[C_RIGHT]) begin
         sel_oh[C_RIGHT] = 1'b1;
         sel_code        = CODE_RIGHT;
      end else if (pend_eff[C_GRAV]) begin
         sel_oh[C_GRAV] = 1'b1;
         sel_code       = CODE_GRAV;
      end
   end

   assign pend_d = halt ? '0 : ((pend_eff & ~(sel_oh & {NCMD{take}})) | ev);

   always_comb begin
      state_d = state_q;
      valid_d = cmd_valid;
      code_d  = cmd_code;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (game_over) begin
               state_d = HALTED;
               valid_d = 1'b0;
               code_d  = CODE_NONE;
            end else if (|pend_eff) begin
               take    = 1'b1;
               state_d = OFFER;
               valid_d = 1'b1;
               code_d  = sel_code;
            end
         end
         OFFER: begin
            if (game_over) begin
               state_d = HALTED;
               valid_d = 1'b0;
               code_d  = CODE_NONE;
            end else if (cmd_ready) begin
               if (|pend_eff) begin
                  take   = 1'b1;
                  code_d = sel_code;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  code_d  = CODE_NONE;
               end
            end
         end
         HALTED: begin
            valid_d = 1'b0;
            code_d  = CODE_NONE;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            code_d  = CODE_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cmd_valid <= 1'b0;
         cmd_code  <= CODE_NONE;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         cmd_valid <= valid_d;
         cmd_code  <= code_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_game_command_scheduler.sv
// Directed bench for game_command_scheduler with short timer parameters
// (gravity 20, first repeat 6, repeat period 3); cycle c means "after edge c".
module tb_game_command_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       right_move_button = 1'b0;
   logic       left_move_button = 1'b0;
   logic       direct_down_button = 1'b0;
   logic       hold_button = 1'b0;
   logic       game_over = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd_code;

   int total = 0;
   int bad   = 0;

   game_command_scheduler #(
      .GRAVITY_PERIOD(20),
      .DAS_DELAY     (6),
      .DAS_REPEAT    (3),
      .CNT_W         (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .right_move_button (right_move_button),
      .left_move_button  (left_move_button),
      .direct_down_button(direct_down_button),
      .hold_button       (hold_button),
      .game_over         (game_over),
      .cmd_ready         (cmd_ready),
      .cmd_valid         (cmd_valid),
      .cmd_code          (cmd_code)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      right_move_button  = 1'b0;
      left_move_button   = 1'b0;
      direct_down_button = 1'b0;
      hold_button        = 1'b0;
      game_over          = 1'b0;
      cmd_ready          = 1'b0;
   endtask

   // release lands #1 after an edge, so the next edge is cycle 1
   task automatic do_reset;
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      #1;
      reset       = 1'b0;
      hold_button = 1'b1;
      cmd_ready   = 1'b1;
      repeat (3) tick();
      total++;
      if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
         bad++;
         $display("FAIL reset_state valid=%b code=%0d expected valid=0 code=0", cmd_valid, cmd_code);
      end
      do_reset();
   endtask

   task automatic test_hold_pulse;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      cmd_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         hold_button = (c == 1);
         tick();
         exp_v = (c == 4);
         exp_c = exp_v ? 3'd4 : 3'd0;
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL hold_pulse c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
   endtask

   task automatic test_right_repeat;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      cmd_ready = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         right_move_button = (c <= 30);
         tick();
         exp_v = (c inside {4, 10, 13, 16, 19, 21, 22, 25, 28, 31, 41});
         exp_c = !exp_v ? 3'd0 : ((c == 21 || c == 41) ? 3'd5 : 3'd2);
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL right_repeat c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
      right_move_button = 1'b0;
   endtask

   task automatic test_priority_stall;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      for (int c = 1; c <= 35; c++) begin
         left_move_button   = (c == 1);
         right_move_button  = (c == 1);
         direct_down_button = (c == 1);
         hold_button        = (c == 1);
         cmd_ready          = (c > 10);
         tick();
         if (c >= 4 && c <= 10) exp_c = 3'd4;
         else if (c == 11)      exp_c = 3'd3;
         else if (c == 12)      exp_c = 3'd1;
         else if (c == 13)      exp_c = 3'd2;
         else if (c == 33)      exp_c = 3'd5;
         else                   exp_c = 3'd0;
         exp_v = (exp_c != 3'd0);
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL priority_stall c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
   endtask

   task automatic test_coalesce;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      for (int c = 1; c <= 30; c++) begin
         hold_button      = (c == 1);
         left_move_button = (c == 5 || c == 8 || c == 11);
         cmd_ready        = (c > 15);
         tick();
         if (c >= 4 && c <= 15) exp_c = 3'd4;
         else if (c == 16)      exp_c = 3'd1;
         else                   exp_c = 3'd0;
         exp_v = (exp_c != 3'd0);
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL coalesce c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
   endtask

   task automatic test_game_over;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      for (int c = 1; c <= 45; c++) begin
         hold_button        = (c == 1);
         direct_down_button = (c == 10);
         right_move_button  = (c >= 12 && c <= 20);
         cmd_ready          = (c >= 8);
         game_over          = (c >= 6 && c < 30);
         tick();
         exp_v = (c == 4 || c == 5);
         exp_c = exp_v ? 3'd4 : 3'd0;
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL game_over c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset;
      logic       exp_v;
      logic [2:0] exp_c;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         hold_button = (c == 1);
         tick();
      end
      total++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin
         bad++;
         $display("FAIL async_reset_offer valid=%b code=%0d expected valid=1 code=4", cmd_valid, cmd_code);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
         bad++;
         $display("FAIL async_reset_drop valid=%b code=%0d expected valid=0 code=0", cmd_valid, cmd_code);
      end
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      cmd_ready = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         exp_v = (c == 21);
         exp_c = exp_v ? 3'd5 : 3'd0;
         total++;
         if (cmd_valid !== exp_v || cmd_code !== exp_c) begin
            bad++;
            $display("FAIL after_reset c=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     c, cmd_valid, cmd_code, exp_v, exp_c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold_pulse();
      test_right_repeat();
      test_priority_stall();
      test_coalesce();
      test_game_over();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
